// File: rtl/segment_scan_ctrl_if.sv
// Display-sequencer bus: control/data sources in, scan phase, digit mask and
// latched display word out. The controller takes the slave side.
interface segment_scan_ctrl_if;
  logic        enable;
  logic        edit_mode;
  logic [1:0]  edit_field;
  logic        blink_sync;
  logic [11:0] time_data;
  logic [11:0] set_data;
  logic [2:0]  byte_status;
  logic [3:0]  segment_byte_control;
  logic [11:0] data_show;
  logic        frame_tick;

  modport master (
    output enable, edit_mode, edit_field, blink_sync, time_data, set_data,
    input  byte_status, segment_byte_control, data_show, frame_tick
  );

  modport slave (
    input  enable, edit_mode, edit_field, blink_sync, time_data, set_data,
    output byte_status, segment_byte_control, data_show, frame_tick
  );
endinterface

// File: rtl/segment_scan_ctrl.sv
// Scan sequencer for a 4-digit 7-segment display: steps the scan phase, blinks
// the digits of the field being edited and latches the shown word only at
// frame boundaries so the display never tears.
module segment_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input logic                clock,
  input logic                reset,
  segment_scan_ctrl_if.slave bus
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PreW-1:0] PreLast  = PreW'(SCAN_DIV - 1);
  localparam logic [BlkW-1:0] BlkLast  = BlkW'(BLINK_FRAMES - 1);
  localparam logic [5:0]      FieldMax = 6'd59;

  typedef enum logic {PhVisible, PhHidden} blink_phase_e;

  logic [PreW-1:0] prescaler_q, prescaler_d;
  logic [2:0]      byte_status_q, byte_status_d;
  logic            frame_tick_q, frame_tick_d;
  logic [11:0]     data_show_q, data_show_d;
  logic            load_pending_q, load_pending_d;
  logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e    blink_phase_q, blink_phase_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      edit_field_q;

  logic        step;
  logic        wrap;
  logic        edit_change;
  logic [11:0] src;

  function automatic logic [5:0] sat_field(input logic [5:0] f);
    return (f > FieldMax) ? FieldMax : f;
  endfunction

  assign step        = bus.enable && (prescaler_q == PreLast);
  assign wrap        = step && (byte_status_q == 3'd7);
  assign edit_change = (bus.edit_field != edit_field_q);
  assign src         = bus.edit_mode ? bus.set_data : bus.time_data;

  // Next-state for scan, data latch, blink and the digit mask.
  always_comb begin
    prescaler_d    = prescaler_q;
    byte_status_d  = byte_status_q;
    frame_tick_d   = 1'b0;
    data_show_d    = data_show_q;
    load_pending_d = load_pending_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    mask_d         = 4'b0000;

    if (!bus.enable) begin
      // Display off: scan parked at phase 0, next enable reloads the word.
      prescaler_d    = '0;
      byte_status_d  = 3'd0;
      blink_cnt_d    = '0;
      blink_phase_d  = PhVisible;
      load_pending_d = 1'b1;
    end else begin
      prescaler_d  = step ? '0 : prescaler_q + PreW'(1);
      frame_tick_d = wrap;
      if (step) begin
        byte_status_d = byte_status_q + 3'd1;
      end
      if (wrap || load_pending_q) begin
        data_show_d    = {sat_field(src[11:6]), sat_field(src[5:0])};
        load_pending_d = 1'b0;
      end
      // A restart request wins over a toggle falling on the same frame.
      if (bus.blink_sync || edit_change) begin
        blink_cnt_d   = '0;
        blink_phase_d = PhVisible;
      end else if (wrap) begin
        if (blink_cnt_q == BlkLast) begin
          blink_cnt_d   = '0;
          blink_phase_d = (blink_phase_q == PhVisible) ? PhHidden : PhVisible;
        end else begin
          blink_cnt_d = blink_cnt_q + BlkW'(1);
        end
      end
      // Mask follows the phase being registered now, so both change together.
      mask_d = 4'b1111;
      if (blink_phase_d == PhHidden) begin
        if (bus.edit_field[0]) mask_d[1:0] = 2'b00;
        if (bus.edit_field[1]) mask_d[3:2] = 2'b00;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_q    <= '0;
      byte_status_q  <= 3'd0;
      frame_tick_q   <= 1'b0;
      data_show_q    <= 12'd0;
      load_pending_q <= 1'b1;
      blink_cnt_q    <= '0;
      blink_phase_q  <= PhVisible;
      mask_q         <= 4'b0000;
      edit_field_q   <= 2'b00;
    end else begin
      prescaler_q    <= prescaler_d;
      byte_status_q  <= byte_status_d;
      frame_tick_q   <= frame_tick_d;
      data_show_q    <= data_show_d;
      load_pending_q <= load_pending_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      mask_q         <= mask_d;
      edit_field_q   <= bus.edit_field;
    end
  end

  assign bus.byte_status          = byte_status_q;
  assign bus.segment_byte_control = mask_q;
  assign bus.data_show            = data_show_q;
  assign bus.frame_tick           = frame_tick_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Scoreboard bench for segment_scan_ctrl (SCAN_DIV = 4, BLINK_FRAMES = 2).
// Stimulus queues cycle-tagged expectations; the monitor compares on negedge.
module tb_segment_scan_ctrl;

  localparam int SelBs   = 0;
  localparam int SelMask = 1;
  localparam int SelDs   = 2;
  localparam int SelFt   = 3;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  segment_scan_ctrl_if bus_if ();

  segment_scan_ctrl #(
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      SelBs:   return "byte_status";
      SelMask: return "segment_byte_control";
      SelDs:   return "data_show";
      default: return "frame_tick";
    endcase
  endfunction

  task automatic push(input int c, input int sel, input int val);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > c) i--;
    exp_q.insert(i, e);
  endtask

  // Expected scan position for a run that was enabled while cyc == base.
  task automatic scan_exp(input int base, input int from, input int to);
    for (int c = from; c <= to; c++) begin
      push(c, SelBs, ((c - base) / 4) % 8);
      push(c, SelFt, ((c - base) % 32 == 0) ? 1 : 0);
    end
  endtask

  task automatic range_exp(input int from, input int to, input int sel, input int val);
    for (int c = from; c <= to; c++) push(c, sel, val);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: pops every expectation due this cycle and compares.
  always @(negedge clock) begin
    exp_t e;
    int   act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.sel)
        SelBs:   act = int'(bus_if.byte_status);
        SelMask: act = int'(bus_if.segment_byte_control);
        SelDs:   act = int'(bus_if.data_show);
        default: act = int'(bus_if.frame_tick);
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s expectation for cycle %0d missed (now %0d)", sel_name(e.sel), e.cyc, cyc);
      end else if (act != e.val) begin
        errors++;
        $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", sel_name(e.sel), cyc, act,
                 e.val);
      end
    end
  end

  int b, b2, b3;

  initial begin
    reset                  = 1'b1;
    bus_if.enable          = 1'b0;
    bus_if.edit_mode       = 1'b0;
    bus_if.edit_field      = 2'b00;
    bus_if.blink_sync      = 1'b0;
    bus_if.time_data       = 12'h000;
    bus_if.set_data        = 12'h000;

    // Reset values.
    push(2, SelBs, 0);
    push(2, SelMask, 0);
    push(2, SelDs, 0);
    push(2, SelFt, 0);
    wait_cyc(3);
    reset = 1'b0;

    // 1: enable, first load and basic scan.
    wait_cyc(5);
    b = cyc;
    bus_if.enable    = 1'b1;
    bus_if.time_data = 12'h3AF;
    push(b + 1, SelDs, 'h3AF);
    push(b + 20, SelDs, 'h3AF);
    scan_exp(b, b + 1, b + 34);
    range_exp(b + 1, b + 34, SelMask, 'hF);

    // 2: saturation of both fields at the next frame.
    wait_cyc(b + 34);
    bus_if.time_data = 12'hFFC;
    push(b + 63, SelDs, 'h3AF);
    push(b + 64, SelDs, 'hEFB);
    scan_exp(b, b + 60, b + 66);
    // Blink phase is hidden here but edit_field = 00 never blanks.
    range_exp(b + 70, b + 90, SelMask, 'hF);

    // 3: source change mid-frame shows only after the wrap.
    wait_cyc(b + 77);
    push(b + 77, SelBs, 3);
    bus_if.time_data = 12'h2C5;
    push(b + 78, SelDs, 'hEFB);
    push(b + 95, SelDs, 'hEFB);
    push(b + 96, SelDs, 'h2C5);
    wait_cyc(b + 100);
    bus_if.edit_mode = 1'b1;
    bus_if.set_data  = 12'h041;
    push(b + 101, SelDs, 'h2C5);
    push(b + 127, SelDs, 'h2C5);
    push(b + 128, SelDs, 'h041);

    // 4: blink of the high field, then blink_sync restart, then both fields.
    wait_cyc(b + 130);
    bus_if.edit_field = 2'b10;
    range_exp(b + 131, b + 191, SelMask, 'hF);
    range_exp(b + 192, b + 255, SelMask, 'h3);
    range_exp(b + 256, b + 319, SelMask, 'hF);
    range_exp(b + 320, b + 330, SelMask, 'h3);
    wait_cyc(b + 330);
    bus_if.blink_sync = 1'b1;
    range_exp(b + 331, b + 383, SelMask, 'hF);
    range_exp(b + 384, b + 390, SelMask, 'h3);
    wait_cyc(b + 331);
    bus_if.blink_sync = 1'b0;
    wait_cyc(b + 390);
    bus_if.edit_field = 2'b11;
    range_exp(b + 391, b + 447, SelMask, 'hF);
    range_exp(b + 448, b + 469, SelMask, 'h0);
    scan_exp(b, b + 440, b + 469);

    // 5: drop enable at phase 5, then re-enable with a saturating set word.
    wait_cyc(b + 469);
    bus_if.enable = 1'b0;
    range_exp(b + 470, b + 489, SelBs, 0);
    range_exp(b + 470, b + 489, SelFt, 0);
    range_exp(b + 470, b + 489, SelMask, 0);
    range_exp(b + 470, b + 489, SelDs, 'h041);
    wait_cyc(b + 485);
    bus_if.set_data = 12'h7FF;
    wait_cyc(b + 490);
    b2 = cyc;
    bus_if.enable = 1'b1;
    push(b2 + 1, SelDs, 'h7FB);
    scan_exp(b2, b2 + 1, b2 + 40);
    range_exp(b2 + 1, b2 + 40, SelMask, 'hF);

    // 6: reset at phase 6 while enabled.
    wait_cyc(b2 + 57);
    push(b2 + 57, SelBs, 6);
    reset = 1'b1;
    for (int c = b2 + 58; c <= b2 + 59; c++) begin
      push(c, SelBs, 0);
      push(c, SelMask, 0);
      push(c, SelDs, 0);
      push(c, SelFt, 0);
    end
    wait_cyc(b2 + 59);
    reset = 1'b0;
    b3 = cyc;
    push(b3 + 1, SelDs, 'h7FB);
    scan_exp(b3, b3 + 1, b3 + 36);
    range_exp(b3 + 1, b3 + 36, SelMask, 'hF);

    wait_cyc(b3 + 40);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
